// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared cell codes, winner codes, FSM states and board helpers
package tictactoe_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MOVE = 2'd1,
    CHECK     = 2'd2,
    OVER      = 2'd3
  } state_e;

  // Index 0 is cell 1, index 8 is cell 9.
  typedef logic [8:0][1:0] board_t;

  function automatic logic is_onehot9(input logic [8:0] v);
    return ($countones(v) == 1);
  endfunction

  // One-hot select of the lowest-index empty cell (all zero if the board is full).
  function automatic logic [8:0] lowest_empty(input board_t b);
    logic [8:0] r;
    r = '0;
    for (int i = 8; i >= 0; i--) begin
      if (b[i] == CELL_EMPTY) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Writes mark into every cell selected by sel (callers pass a one-hot sel).
  function automatic board_t place(input board_t b, input logic [8:0] sel, input logic [1:0] mark);
    board_t r;
    r = b;
    for (int i = 0; i < 9; i++) begin
      if (sel[i]) r[i] = mark;
    end
    return r;
  endfunction

endpackage

// File: rtl/tictactoe_board_writer_if.sv
// rtl/tictactoe_board_writer_if.sv - move handshake between the player side and the board writer
interface tictactoe_board_writer_if;
  logic       move_valid;
  logic [8:0] move_sel;
  logic       move_ready;

  modport master (output move_valid, output move_sel, input move_ready);
  modport slave  (input move_valid, input move_sel, output move_ready);
endinterface

// File: rtl/tictactoe_line_checker.sv
// rtl/tictactoe_line_checker.sv - combinational three-in-a-line and full-board detection
module tictactoe_line_checker
  import tictactoe_pkg::*;
(
  input  board_t     cells_i,
  output logic [1:0] win_code_o,
  output logic       board_full_o
);

  function automatic logic [1:0] line_code(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return ((a != CELL_EMPTY) && (a == b) && (b == c)) ? a : CELL_EMPTY;
  endfunction

  logic [7:0][1:0] lc;

  assign lc[0] = line_code(cells_i[0], cells_i[1], cells_i[2]);
  assign lc[1] = line_code(cells_i[3], cells_i[4], cells_i[5]);
  assign lc[2] = line_code(cells_i[6], cells_i[7], cells_i[8]);
  assign lc[3] = line_code(cells_i[0], cells_i[3], cells_i[6]);
  assign lc[4] = line_code(cells_i[1], cells_i[4], cells_i[7]);
  assign lc[5] = line_code(cells_i[2], cells_i[5], cells_i[8]);
  assign lc[6] = line_code(cells_i[0], cells_i[4], cells_i[8]);
  assign lc[7] = line_code(cells_i[2], cells_i[4], cells_i[6]);

  // Pick the first completed line; only one player can own a line when a game ends.
  always_comb begin
    win_code_o = WIN_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (lc[i] != CELL_EMPTY) win_code_o = lc[i];
    end
  end

  // Board is full when no cell is empty.
  always_comb begin
    board_full_o = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (cells_i[i] == CELL_EMPTY) board_full_o = 1'b0;
    end
  end

endmodule

// File: rtl/tictactoe_board_writer.sv
// rtl/tictactoe_board_writer.sv - board state owner: move commit, turn timeout, win/draw detection
module tictactoe_board_writer
  import tictactoe_pkg::*;
#(
  parameter int TURN_TIMEOUT = 1500,
  parameter int TIMER_W      = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  tictactoe_board_writer_if.slave mv,
  output logic [1:0]             pos1,
  output logic [1:0]             pos2,
  output logic [1:0]             pos3,
  output logic [1:0]             pos4,
  output logic [1:0]             pos5,
  output logic [1:0]             pos6,
  output logic [1:0]             pos7,
  output logic [1:0]             pos8,
  output logic [1:0]             pos9,
  output logic                   turn,
  output logic                   illegal_pulse,
  output logic                   timeout_pulse,
  output logic                   game_over,
  output logic [1:0]             winner,
  output logic [TIMER_W-1:0]     turn_timer
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_TIMEOUT - 1);

  state_e               state_q, state_d;
  board_t               board_q, board_d;
  logic                 turn_q, turn_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [1:0]           winner_q, winner_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;

  logic [1:0]           mark;
  logic [8:0]           occupied;
  logic                 move_hs;
  logic                 move_legal;
  logic                 timer_expired;
  logic [1:0]           win_code;
  logic                 board_full;

  tictactoe_line_checker u_line_checker (
    .cells_i      (board_q),
    .win_code_o   (win_code),
    .board_full_o (board_full)
  );

  assign mark          = turn_q ? CELL_P2 : CELL_P1;
  assign move_hs       = mv.move_valid && (state_q == WAIT_MOVE);
  assign move_legal    = is_onehot9(mv.move_sel) && ((occupied & mv.move_sel) == 9'd0);
  assign timer_expired = (timer_q == TIMER_LAST);

  // Occupancy mask used to reject moves onto taken cells.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < 9; i++) begin
      occupied[i] = (board_q[i] != CELL_EMPTY);
    end
  end

  // Next-state logic: start overrides everything; a legal move beats a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    timer_d   = timer_q;
    winner_d  = winner_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    if (start) begin
      board_d  = '0;
      turn_d   = 1'b0;
      timer_d  = '0;
      winner_d = WIN_NONE;
      state_d  = WAIT_MOVE;
    end else begin
      case (state_q)
        IDLE: begin
        end
        WAIT_MOVE: begin
          if (!timer_expired) timer_d = timer_q + 1'b1;
          illegal_d = move_hs && !move_legal;
          if (move_hs && move_legal) begin
            board_d = place(board_q, mv.move_sel, mark);
            state_d = CHECK;
          end else if (timer_expired) begin
            board_d   = place(board_q, lowest_empty(board_q), mark);
            timeout_d = 1'b1;
            state_d   = CHECK;
          end
        end
        CHECK: begin
          if (win_code != WIN_NONE) begin
            winner_d = win_code;
            state_d  = OVER;
          end else if (board_full) begin
            winner_d = WIN_DRAW;
            state_d  = OVER;
          end else begin
            turn_d  = ~turn_q;
            timer_d = '0;
            state_d = WAIT_MOVE;
          end
        end
        OVER: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous clear so outputs drop as soon as reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      board_q   <= '0;
      turn_q    <= 1'b0;
      timer_q   <= '0;
      winner_q  <= WIN_NONE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      timer_q   <= timer_d;
      winner_q  <= winner_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign mv.move_ready   = (state_q == WAIT_MOVE);
  assign game_over       = (state_q == OVER);
  assign turn            = turn_q;
  assign winner          = winner_q;
  assign turn_timer      = timer_q;
  assign illegal_pulse   = illegal_q;
  assign timeout_pulse   = timeout_q;
  assign pos1            = board_q[0];
  assign pos2            = board_q[1];
  assign pos3            = board_q[2];
  assign pos4            = board_q[3];
  assign pos5            = board_q[4];
  assign pos6            = board_q[5];
  assign pos7            = board_q[6];
  assign pos8            = board_q[7];
  assign pos9            = board_q[8];

endmodule

// File: doc/tictactoe_board_writer.md
Name: tictactoe_board_writer

Overview:
Owns the tic-tac-toe board state and produces the nine 2-bit cell codes that the board display and the illegal-move checking path consume. It accepts one-hot move selects from the player whose turn it is and rejects moves onto occupied cells or non-one-hot selects. It commits legal moves, alternates turns and enforces a per-turn timeout by auto-placing a mark. After every commit it detects a win or a draw.

Parameters:
TURN_TIMEOUT, 1500, cycles allowed per turn in WAIT_MOVE before an auto-place (must be >= 2)
TIMER_W, 11, width of the turn timer; must hold TURN_TIMEOUT-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  synchronous new-game request; highest priority
move_valid  in  1  current player presents a move
move_sel  in  9  one-hot cell select; bit0 = cell 1 … bit8 = cell 9
move_ready  out  1  high only in WAIT_MOVE
pos1..pos9  out  2 each  cell code: 00 empty, 01 player 1, 10 player 2 (11 never driven)
turn  out  1  0 = player 1 to move, 1 = player 2 to move
illegal_pulse  out  1  one-cycle flag when a move is rejected
timeout_pulse  out  1  one-cycle flag when an auto-place occurs
game_over  out  1  high in OVER
winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw
turn_timer  out  TIMER_W  current turn timer value

Behaviour:
- Reset (async, rst_n=0): all posN=00, turn=0, timer=0, winner=00, all pulses 0, state=IDLE. Outputs clear immediately, also when reset arrives mid-game.
- States:
  - IDLE: move_ready=0; waits for start.
  - WAIT_MOVE: move_ready=1; timer increments every cycle.
  - CHECK: one cycle; move_ready=0.
  - OVER: game_over=1; moves are ignored.
- start=1 in any state: at the next edge the board is cleared, turn=0, timer=0, winner=00, state=WAIT_MOVE.
- Move accept: the handshake is the cycle T where move_valid=1 and state is WAIT_MOVE.
  - A move is legal when move_sel is exactly one-hot and the selected cell is 00.
  - Legal: at T+1 the selected cell reads 01 (turn=0) or 10 (turn=1); state=CHECK.
  - Illegal: illegal_pulse=1 during T+1 only; board, turn and timer are unaffected (the timer keeps counting); state stays WAIT_MOVE.
- Timeout: when the timer equals TURN_TIMEOUT-1 in WAIT_MOVE and no legal move is accepted that cycle, the current player's mark is written into the lowest-index empty cell. timeout_pulse=1 during the next cycle, then state=CHECK. An empty cell always exists in WAIT_MOVE.
- Simultaneous legal move and timeout: the move wins and there is no timeout_pulse. Simultaneous illegal move and timeout: both pulses assert and the auto-place happens.
- CHECK (cycle T+1), evaluated on the updated board:
  - Any of the 8 lines (3 rows, 3 columns, 2 diagonals) holding three equal non-empty codes: winner = that code, state=OVER.
  - Otherwise, all 9 cells non-empty: winner=11, state=OVER.
  - Otherwise: turn toggles, timer=0, state=WAIT_MOVE. The new turn and move_ready=1 are visible at T+2.
- Total latency from a legal accept to the next accept opportunity is 2 cycles.
- The timer saturates and never wraps, because the timeout forces an exit from WAIT_MOVE.

Decomposition:
- tictactoe_pkg holds:
  - cell codes CELL_EMPTY=2'b00, CELL_P1=2'b01, CELL_P2=2'b10
  - WIN_NONE/WIN_P1/WIN_P2/WIN_DRAW
  - the state enum (IDLE, WAIT_MOVE, CHECK, OVER)
- Sub-module tictactoe_line_checker: combinational; takes the 9 cells and returns win_code[1:0] and board_full. It is instantiated once and reused by the verification scoreboard.

Test Plan:
- Reset, then start pulse -> all posN=00, move_ready=1, turn=0, winner=00. Assert rst_n=0 mid-game -> the board clears in the same cycle, without waiting for a clock edge.
- Player 1 move_sel=9'b000010000 -> pos5=01 at T+1, turn=1 and move_ready=1 at T+2, turn_timer=0.
- Player 2 move_sel=9'b000010000 (occupied) -> illegal_pulse for 1 cycle, pos5 stays 01, turn stays 1. Then move_sel=9'b000000011 -> illegal_pulse. Then move_sel=0 with move_valid=1 -> illegal_pulse.
- With TURN_TIMEOUT=8 and only pos5 filled, no move for 8 cycles -> pos1=10 (player 2), timeout_pulse for 1 cycle, turn=0 two cycles later. A legal move on the timeout cycle -> no auto-place.
- Player 1 fills cells 1, 2, 3 with interleaved player 2 moves -> winner=01, game_over=1, move_ready=0. A further move_valid -> no change. start -> fresh board, turn=0.
- Sequence 1,2,3,5,4,6,8,7,9 (alternating, no line) -> after the ninth commit winner=11, game_over=1. A start during CHECK -> the board clears and winner=00.
